shot_resolver: RTL and testbench

Consumes the 3-bit shot state from the firing controller and turns each new shot into a screen-flash window and a hit/miss decision against the duck's hitbox. Keeps per-round counts of shots fired and hits, and latches a duck-down flag. Sits between the firing controller and the scoring/duck-motion logic, and drives the flash overlay in the video path.

---
 rtl/shot_resolver_pkg.sv | 27 ++
 rtl/shot_resolver_hitbox_check.sv | 40 ++++
 rtl/shot_resolver.sv | 165 ++++++++++++++++
 tb/tb_shot_resolver.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_resolver_pkg.sv
// Shared game definitions: firing-controller shot_state codes, screen
// coordinate widths shared with the duck-motion block, and resolver FSM states.
package shot_resolver_pkg;

  localparam int SCREEN_X_W = 8;
  localparam int SCREEN_Y_W = 7;

  localparam logic [2:0] SHOT_PRELOAD = 3'b110;
  localparam logic [2:0] SHOT_HOLD1   = 3'b000;
  localparam logic [2:0] SHOT_SHOT1   = 3'b001;
  localparam logic [2:0] SHOT_HOLD2   = 3'b010;
  localparam logic [2:0] SHOT_SHOT2   = 3'b011;
  localparam logic [2:0] SHOT_HOLD3   = 3'b100;
  localparam logic [2:0] SHOT_SHOT3   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_EVAL  = 2'd2
  } resolver_state_e;

  // Only the three real shot codes can start a shot; 111 is not a valid code.
  function automatic logic is_shot_code(input logic [2:0] code);
    return (code == SHOT_SHOT1) || (code == SHOT_SHOT2) || (code == SHOT_SHOT3);
  endfunction

endpackage

// File: rtl/shot_resolver_hitbox_check.sv
// Combinational hitbox test. Bounds are computed one bit wider than the screen
// coordinates so a hitbox hanging past the right/bottom edge never wraps.
module hitbox_check
  import shot_resolver_pkg::*;
#(
  parameter int DUCK_W = 16,
  parameter int DUCK_H = 16
) (
  input  logic [SCREEN_X_W-1:0] aim_x,
  input  logic [SCREEN_Y_W-1:0] aim_y,
  input  logic [SCREEN_X_W-1:0] duck_x,
  input  logic [SCREEN_Y_W-1:0] duck_y,
  input  logic                  duck_alive,
  output logic                  hit
);

  localparam int XW = SCREEN_X_W + 1;
  localparam int YW = SCREEN_Y_W + 1;

  logic [XW-1:0] ax_s;
  logic [XW-1:0] left_s;
  logic [XW-1:0] right_s;
  logic [YW-1:0] ay_s;
  logic [YW-1:0] top_s;
  logic [YW-1:0] bottom_s;
  logic          in_x_s;
  logic          in_y_s;

  assign ax_s     = {1'b0, aim_x};
  assign left_s   = {1'b0, duck_x};
  assign right_s  = {1'b0, duck_x} + XW'(DUCK_W - 1);
  assign ay_s     = {1'b0, aim_y};
  assign top_s    = {1'b0, duck_y};
  assign bottom_s = {1'b0, duck_y} + YW'(DUCK_H - 1);

  assign in_x_s = (ax_s >= left_s) && (ax_s <= right_s);
  assign in_y_s = (ay_s >= top_s) && (ay_s <= bottom_s);
  assign hit    = in_x_s && in_y_s && duck_alive;

endmodule

// File: rtl/shot_resolver.sv
// Turns firing-controller shot events into a flash window followed by a
// hit/miss resolution, with per-round shot/hit counters and a duck-down latch.
module shot_resolver
  import shot_resolver_pkg::*;
#(
  parameter int FLASH_CYCLES = 4,
  parameter int DUCK_W       = 16,
  parameter int DUCK_H       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            shot_state,
  input  logic [SCREEN_X_W-1:0] aim_x,
  input  logic [SCREEN_Y_W-1:0] aim_y,
  input  logic [SCREEN_X_W-1:0] duck_x,
  input  logic [SCREEN_Y_W-1:0] duck_y,
  input  logic                  duck_alive,
  input  logic                  round_clear,
  output logic                  flash,
  output logic                  shot_done,
  output logic                  shot_hit,
  output logic [1:0]            shots_fired,
  output logic [1:0]            hits,
  output logic                  duck_down,
  output logic                  out_of_ammo
);

  localparam int CNT_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_CYCLES - 1);

  resolver_state_e       state_r;
  logic [2:0]            prev_state_r;
  logic [1:0]            pending_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [SCREEN_X_W-1:0] aim_x_r;
  logic [SCREEN_Y_W-1:0] aim_y_r;
  logic [SCREEN_X_W-1:0] duck_x_r;
  logic [SCREEN_Y_W-1:0] duck_y_r;
  logic                  alive_r;
  logic                  event_s;
  logic                  go_s;
  logic                  hit_s;

  // A shot event is a change onto one of the three shot codes.
  assign event_s = is_shot_code(shot_state) && (shot_state != prev_state_r);

  // Leave IDLE whenever something is queued or a shot arrives right now.
  assign go_s = (state_r == ST_IDLE) && ((pending_r != 2'd0) || event_s) && !round_clear;

  hitbox_check #(
    .DUCK_W (DUCK_W),
    .DUCK_H (DUCK_H)
  ) u_hitbox_check (
    .aim_x      (aim_x_r),
    .aim_y      (aim_y_r),
    .duck_x     (duck_x_r),
    .duck_y     (duck_y_r),
    .duck_alive (alive_r),
    .hit        (hit_s)
  );

  // Edge detector history; keeps tracking even across round_clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_state_r <= SHOT_PRELOAD;
    end else begin
      prev_state_r <= shot_state;
    end
  end

  // Queue of shots that arrived while the FSM was busy, saturating at 3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= 2'd0;
    end else if (round_clear) begin
      pending_r <= 2'd0;
    end else if (event_s && !go_s) begin
      if (pending_r != 2'd3) begin
        pending_r <= pending_r + 2'd1;
      end
    end else if (go_s && !event_s) begin
      pending_r <= pending_r - 2'd1;
    end
  end

  // Shot FSM: snapshot and flash, then resolve and update round counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      aim_x_r     <= '0;
      aim_y_r     <= '0;
      duck_x_r    <= '0;
      duck_y_r    <= '0;
      alive_r     <= 1'b0;
      flash       <= 1'b0;
      shot_done   <= 1'b0;
      shot_hit    <= 1'b0;
      shots_fired <= 2'd0;
      hits        <= 2'd0;
      duck_down   <= 1'b0;
      out_of_ammo <= 1'b0;
    end else if (round_clear) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      flash       <= 1'b0;
      shot_done   <= 1'b0;
      shot_hit    <= 1'b0;
      shots_fired <= 2'd0;
      hits        <= 2'd0;
      duck_down   <= 1'b0;
      out_of_ammo <= 1'b0;
    end else begin
      shot_done <= 1'b0;
      shot_hit  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            state_r     <= ST_FLASH;
            cnt_r       <= CNT_LOAD;
            flash       <= 1'b1;
            aim_x_r     <= aim_x;
            aim_y_r     <= aim_y;
            duck_x_r    <= duck_x;
            duck_y_r    <= duck_y;
            alive_r     <= duck_alive;
            out_of_ammo <= 1'b0;
          end else begin
            out_of_ammo <= (shots_fired == 2'd3);
          end
        end
        ST_FLASH: begin
          out_of_ammo <= 1'b0;
          if (cnt_r == '0) begin
            state_r <= ST_EVAL;
            flash   <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        ST_EVAL: begin
          state_r   <= ST_IDLE;
          shot_done <= 1'b1;
          shot_hit  <= hit_s;
          if (shots_fired != 2'd3) begin
            shots_fired <= shots_fired + 2'd1;
          end
          if (hit_s) begin
            if (hits != 2'd3) begin
              hits <= hits + 2'd1;
            end
            duck_down <= 1'b1;
          end
          // This resolution used the last shot of the round and nothing follows.
          out_of_ammo <= (shots_fired >= 2'd2) && (pending_r == 2'd0) && !event_s;
        end
        default: begin
          state_r <= ST_IDLE;
          flash   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shot_resolver.sv
// Self-checking bench for shot_resolver: directed scenarios plus a randomized
// run compared against a timing-level reference model.
module tb_shot_resolver;

  localparam int F = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] shot_state = 3'b110;
  logic [7:0] aim_x = 8'd0;
  logic [6:0] aim_y = 7'd0;
  logic [7:0] duck_x = 8'd0;
  logic [6:0] duck_y = 7'd0;
  logic       duck_alive = 1'b0;
  logic       round_clear = 1'b0;
  logic       flash;
  logic       shot_done;
  logic       shot_hit;
  logic [1:0] shots_fired;
  logic [1:0] hits;
  logic       duck_down;
  logic       out_of_ammo;

  int tests_run = 0;
  int tests_failed = 0;

  shot_resolver #(
    .FLASH_CYCLES (F),
    .DUCK_W       (16),
    .DUCK_H       (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .shot_state  (shot_state),
    .aim_x       (aim_x),
    .aim_y       (aim_y),
    .duck_x      (duck_x),
    .duck_y      (duck_y),
    .duck_alive  (duck_alive),
    .round_clear (round_clear),
    .flash       (flash),
    .shot_done   (shot_done),
    .shot_hit    (shot_hit),
    .shots_fired (shots_fired),
    .hits        (hits),
    .duck_down   (duck_down),
    .out_of_ammo (out_of_ammo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_round();
    round_clear = 1'b1;
    step();
    round_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    tests_run++;
    if ({flash, shot_done, shot_hit, shots_fired, hits, duck_down, out_of_ammo} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, want 000000000",
               {flash, shot_done, shot_hit, shots_fired, hits, duck_down, out_of_ammo});
    end
    #3 reset_n = 1'b1;
    step();
    tests_run++;
    if ({flash, shot_done, shots_fired} !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: flash=%b done=%b fired=%0d, want 0/0/0", flash, shot_done, shots_fired);
    end
  endtask

  task automatic test_single_hit();
    aim_x = 8'd40; aim_y = 7'd30; duck_x = 8'd32; duck_y = 7'd24; duck_alive = 1'b1;
    shot_state = 3'b110; step();
    shot_state = 3'b000; step();
    shot_state = 3'b001; step();
    for (int i = 0; i < F; i++) begin
      tests_run++;
      if (flash !== 1'b1 || shot_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_flash E+%0d: flash=%b done=%b, want 1/0", i, flash, shot_done);
      end
      step();
    end
    tests_run++;
    if (flash !== 1'b0 || shot_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_eval: flash=%b done=%b, want 0/0", flash, shot_done);
    end
    step();
    tests_run++;
    if (shot_done !== 1'b1 || shot_hit !== 1'b1 || shots_fired !== 2'd1 || hits !== 2'd1 || duck_down !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_done: done=%b hit=%b fired=%0d hits=%0d down=%b, want 1/1/1/1/1",
               shot_done, shot_hit, shots_fired, hits, duck_down);
    end
    step();
    tests_run++;
    if (shot_done !== 1'b0 || shot_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pulse_width: done=%b hit=%b, want 0/0", shot_done, shot_hit);
    end
  endtask

  task automatic test_edge_miss();
    clear_round();
    aim_x = 8'd48; aim_y = 7'd30; duck_x = 8'd32; duck_y = 7'd24; duck_alive = 1'b1;
    shot_state = 3'b011; step();
    repeat (F + 1) step();
    tests_run++;
    if (shot_done !== 1'b1 || shot_hit !== 1'b0 || hits !== 2'd0 || shots_fired !== 2'd1) begin
      tests_failed++;
      $display("FAIL edge_miss: done=%b hit=%b hits=%0d fired=%0d, want 1/0/0/1",
               shot_done, shot_hit, hits, shots_fired);
    end
    aim_x = 8'd47; aim_y = 7'd39;
    shot_state = 3'b101; step();
    repeat (F + 1) step();
    tests_run++;
    if (shot_done !== 1'b1 || shot_hit !== 1'b1 || hits !== 2'd1 || shots_fired !== 2'd2) begin
      tests_failed++;
      $display("FAIL edge_corner_hit: done=%b hit=%b hits=%0d fired=%0d, want 1/1/1/2",
               shot_done, shot_hit, hits, shots_fired);
    end
  endtask

  task automatic test_back_to_back();
    clear_round();
    aim_x = 8'd40; aim_y = 7'd30; duck_x = 8'd32; duck_y = 7'd24; duck_alive = 1'b1;
    shot_state = 3'b110; step();
    shot_state = 3'b000; step();
    shot_state = 3'b001; step();
    shot_state = 3'b010; step();
    shot_state = 3'b011; step();
    repeat (3) step();
    tests_run++;
    if (shot_done !== 1'b1 || flash !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first_done: done=%b flash=%b, want 1/0", shot_done, flash);
    end
    step();
    tests_run++;
    if (flash !== 1'b1 || out_of_ammo !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second_flash: flash=%b ammo=%b at E+6, want 1/0", flash, out_of_ammo);
    end
    repeat (F + 1) step();
    tests_run++;
    if (shot_done !== 1'b1 || shots_fired !== 2'd2 || out_of_ammo !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second_done: done=%b fired=%0d ammo=%b, want 1/2/0", shot_done, shots_fired, out_of_ammo);
    end
    shot_state = 3'b100; step();
    shot_state = 3'b101; step();
    repeat (F) step();
    tests_run++;
    if (out_of_ammo !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ammo_early: ammo=%b before third done, want 0", out_of_ammo);
    end
    step();
    tests_run++;
    if (shot_done !== 1'b1 || shots_fired !== 2'd3 || hits !== 2'd3) begin
      tests_failed++;
      $display("FAIL b2b_third_done: done=%b fired=%0d hits=%0d, want 1/3/3", shot_done, shots_fired, hits);
    end
    step();
    tests_run++;
    if (out_of_ammo !== 1'b1 || shot_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_out_of_ammo: ammo=%b done=%b, want 1/0", out_of_ammo, shot_done);
    end
  endtask

  task automatic test_wide_arith();
    clear_round();
    duck_x = 8'd250; duck_y = 7'd24; aim_x = 8'd255; aim_y = 7'd30; duck_alive = 1'b1;
    shot_state = 3'b001; step();
    repeat (F + 1) step();
    tests_run++;
    if (shot_done !== 1'b1 || shot_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL wide_hit: done=%b hit=%b, want 1/1", shot_done, shot_hit);
    end
    aim_x = 8'd5;
    shot_state = 3'b011; step();
    repeat (F + 1) step();
    tests_run++;
    if (shot_done !== 1'b1 || shot_hit !== 1'b0 || hits !== 2'd1) begin
      tests_failed++;
      $display("FAIL wide_no_wrap: done=%b hit=%b hits=%0d, want 1/0/1", shot_done, shot_hit, hits);
    end
  endtask

  task automatic test_round_clear();
    shot_state = 3'b101; step();
    step();
    round_clear = 1'b1;
    shot_state = 3'b001;
    step();
    round_clear = 1'b0;
    tests_run++;
    if (flash !== 1'b0 || shots_fired !== 2'd0 || hits !== 2'd0 || duck_down !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_mid_flash: flash=%b fired=%0d hits=%0d down=%b, want 0/0/0/0",
               flash, shots_fired, hits, duck_down);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      tests_run++;
      if (shot_done !== 1'b0 || flash !== 1'b0) begin
        tests_failed++;
        $display("FAIL clear_quiet %0d: done=%b flash=%b, want 0/0", i, shot_done, flash);
      end
    end
  endtask

  task automatic test_async_reset();
    duck_x = 8'd32; duck_y = 7'd24; aim_x = 8'd40; aim_y = 7'd30; duck_alive = 1'b1;
    shot_state = 3'b011; step();
    repeat (F + 1) step();
    shot_state = 3'b001; step();
    repeat (F) step();
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({flash, shot_done, shot_hit, shots_fired, hits, duck_down, out_of_ammo} !== 9'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %b, want 000000000",
               {flash, shot_done, shot_hit, shots_fired, hits, duck_down, out_of_ammo});
    end
    #3 reset_n = 1'b1;
    step();
    tests_run++;
    if (flash !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_detect: flash=%b, want 1", flash);
    end
    repeat (F + 1) step();
    tests_run++;
    if (shot_done !== 1'b1 || shots_fired !== 2'd1) begin
      tests_failed++;
      $display("FAIL post_reset_done: done=%b fired=%0d, want 1/1", shot_done, shots_fired);
    end
  endtask

  // Reference model: shots start at the first edge the resolver is free
  // (F+2 edges after the previous start), sample inputs there, and resolve
  // at start+F+1.
  task automatic test_random();
    int n, prev, pend, sf, hc, dd, start, free_at;
    int sax, say, sdx, sdy, sal;
    bit ev, mhit, ef, ed, eh;
    logic [7:0] expv, gotv;
    reset_n = 1'b0;
    shot_state = 3'b110;
    round_clear = 1'b0;
    step();
    #3 reset_n = 1'b1;
    prev = 6; pend = 0; sf = 0; hc = 0; dd = 0; start = -1000; free_at = 0;
    sax = 0; say = 0; sdx = 0; sdy = 0; sal = 0;
    for (n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) shot_state = 3'($urandom_range(0, 7));
      round_clear = ($urandom_range(0, 59) == 0);
      duck_alive = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        duck_x = 8'($urandom_range(0, 255));
        duck_y = 7'($urandom_range(0, 127));
      end
      aim_x = 8'(int'(duck_x) + int'($urandom_range(0, 19)) - 2);
      aim_y = 7'(int'(duck_y) + int'($urandom_range(0, 19)) - 2);

      ev = (shot_state == 3'b001 || shot_state == 3'b011 || shot_state == 3'b101) && (int'(shot_state) != prev);
      prev = int'(shot_state);
      ed = 1'b0;
      eh = 1'b0;
      if (round_clear) begin
        pend = 0; sf = 0; hc = 0; dd = 0; start = -1000; free_at = n + 1;
      end else begin
        if (n == start + F + 1) begin
          mhit = (sax >= sdx) && (sax <= sdx + 15) && (say >= sdy) && (say <= sdy + 15) && (sal == 1);
          ed = 1'b1;
          eh = mhit;
          if (sf < 3) sf++;
          if (mhit) begin
            if (hc < 3) hc++;
            dd = 1;
          end
        end
        if (n >= free_at && (pend > 0 || ev)) begin
          start = n;
          free_at = n + F + 2;
          sax = int'(aim_x); say = int'(aim_y); sdx = int'(duck_x); sdy = int'(duck_y); sal = int'(duck_alive);
          if (!ev) pend--;
        end else if (ev && pend < 3) begin
          pend++;
        end
      end
      ef = (n >= start) && (n < start + F);
      expv = {ef, ed, eh, 2'(sf), 2'(hc), dd[0]};
      step();
      gotv = {flash, shot_done, shot_hit, shots_fired, hits, duck_down};
      tests_run++;
      if (gotv !== expv) begin
        tests_failed++;
        $display("FAIL random cycle %0d: got {flash,done,hit,fired,hits,down}=%b, want %b", n, gotv, expv);
      end
    end
    round_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_edge_miss();
    test_back_to_back();
    test_wide_arith();
    test_round_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
